// File: rtl/regfile_2r1w_if.sv
// Core-side bundle for the 2-read/1-write register file: decode drives the read
// addresses, writeback drives the write port, and the file reports busy during a clear.
interface regfile_2r1w_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) ();
    logic              clear_req;
    logic              busy;
    logic [ADDR_W-1:0] ra_addr;
    logic [DATA_W-1:0] ra_data;
    logic [ADDR_W-1:0] rb_addr;
    logic [DATA_W-1:0] rb_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output clear_req, ra_addr, rb_addr, wr_en, wr_addr, wr_data,
        input  busy, ra_data, rb_data
    );

    modport slave (
        input  clear_req, ra_addr, rb_addr, wr_en, wr_addr, wr_data,
        output busy, ra_data, rb_data
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file: two combinational read ports, one synchronous write port, optional
// write-to-read bypass and hardwired-zero entry 0; a sequential clear FSM zeroes the array.
module regfile_2r1w #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic           clk,
    input  logic           rst,
    regfile_2r1w_if.slave  bus
);
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    // One extra pointer bit lets DEPTH == 2**ADDR_W be represented without wrapping.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W:0]   clr_ptr;
    logic              busy_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              ra_hit;
    logic              rb_hit;

    function automatic logic readable(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_C) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    // A clear request in the same cycle takes priority over a write.
    assign wr_ok  = bus.wr_en && !busy_q && !bus.clear_req && readable(bus.wr_addr);
    assign ra_hit = (BYPASS != 0) && wr_ok && (bus.wr_addr == bus.ra_addr);
    assign rb_hit = (BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rb_addr);
    assign bus.busy = busy_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_ptr == LAST_C) begin
                        state   <= S_IDLE;
                        busy_q  <= 1'b0;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + ONE_C;
                    end
                end
                S_IDLE: begin
                    if (bus.clear_req) begin
                        state   <= S_CLEAR;
                        busy_q  <= 1'b1;
                        clr_ptr <= '0;
                    end
                end
            endcase
        end
    end

    // NOTE: the array has no reset; the clear FSM zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_ptr[ADDR_W-1:0]] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // NOTE: each read output gets a default first so no path can infer a latch.
    always_comb begin
        bus.ra_data = '0;
        if (!busy_q && readable(bus.ra_addr)) begin
            bus.ra_data = ra_hit ? bus.wr_data : mem[bus.ra_addr];
        end
    end

    always_comb begin
        bus.rb_data = '0;
        if (!busy_q && readable(bus.rb_addr)) begin
            bus.rb_data = rb_hit ? bus.wr_data : mem[bus.rb_addr];
        end
    end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: a main instance (bypass on), a no-bypass instance
// and a zero-register instance with DEPTH=200, all sharing clk and rst.
module tb_regfile_2r1w;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regfile_2r1w_if #(.DATA_W(8), .ADDR_W(8)) m_if ();
    regfile_2r1w_if #(.DATA_W(8), .ADDR_W(8)) nb_if ();
    regfile_2r1w_if #(.DATA_W(8), .ADDR_W(8)) z_if ();

    regfile_2r1w #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .BYPASS(1), .ZERO_REG(0)) u_main (
        .clk(clk), .rst(rst), .bus(m_if)
    );
    regfile_2r1w #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .BYPASS(0), .ZERO_REG(0)) u_nb (
        .clk(clk), .rst(rst), .bus(nb_if)
    );
    regfile_2r1w #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .BYPASS(1), .ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst), .bus(z_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_addr;
        logic [7:0] wr_data;
        logic [7:0] ra_addr;
        logic [7:0] rb_addr;
        logic [7:0] exp_ra;
        logic [7:0] exp_rb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic count_main_busy(output int n, output int bad);
        n   = 0;
        bad = 0;
        while (m_if.busy && n < 600) begin
            @(negedge clk);
            if (m_if.ra_data !== 8'h00 || m_if.rb_data !== 8'h00) bad++;
            next_cycle();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   n;
        int   bad;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        m_if.clear_req = 1'b0; m_if.wr_en = 1'b0; m_if.wr_addr = '0; m_if.wr_data = '0;
        m_if.ra_addr = 8'h7F;  m_if.rb_addr = 8'hFF;
        nb_if.clear_req = 1'b0; nb_if.wr_en = 1'b0; nb_if.wr_addr = '0; nb_if.wr_data = '0;
        nb_if.ra_addr = '0;     nb_if.rb_addr = '0;
        z_if.clear_req = 1'b0; z_if.wr_en = 1'b0; z_if.wr_addr = '0; z_if.wr_data = '0;
        z_if.ra_addr = '0;     z_if.rb_addr = '0;

        // wr_en, wr_addr, wr_data, ra_addr, rb_addr, exp_ra, exp_rb (array all zero beforehand)
        vecs[0] = '{1'b1, 8'h10, 8'h5A, 8'h10, 8'hFF, 8'h5A, 8'h00};
        vecs[1] = '{1'b1, 8'hFF, 8'hA5, 8'h10, 8'hFF, 8'h5A, 8'hA5};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h5A, 8'hA5};
        vecs[3] = '{1'b1, 8'h20, 8'h11, 8'h00, 8'h7F, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 8'h20, 8'hC3, 8'h20, 8'h20, 8'hC3, 8'hC3};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h20, 8'h10, 8'hC3, 8'h5A};
        vecs[6] = '{1'b1, 8'h00, 8'h01, 8'h00, 8'h20, 8'h01, 8'hC3};
        vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};

        // Reset state and power-up clear length
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_busy", m_if.busy, 1);
        check("reset_ra_zero", m_if.ra_data, 8'h00);
        check("reset_rb_zero", m_if.rb_data, 8'h00);
        next_cycle();
        rst = 1'b0;
        count_main_busy(n, bad);
        check("init_clear_cycles", n, 256);
        check("init_busy_reads_zero", bad, 0);

        m_if.ra_addr = 8'h00; m_if.rb_addr = 8'h7F;
        @(negedge clk);
        check("post_clear_rd_00", m_if.ra_data, 8'h00);
        check("post_clear_rd_7f", m_if.rb_data, 8'h00);
        m_if.ra_addr = 8'hFF;
        #1;
        check("post_clear_rd_ff", m_if.ra_data, 8'h00);
        next_cycle();

        // Table-driven write/read/bypass vectors on the main instance
        for (int i = 0; i < 8; i++) begin
            m_if.wr_en   = vecs[i].wr_en;
            m_if.wr_addr = vecs[i].wr_addr;
            m_if.wr_data = vecs[i].wr_data;
            m_if.ra_addr = vecs[i].ra_addr;
            m_if.rb_addr = vecs[i].rb_addr;
            @(negedge clk);
            check($sformatf("vec%0d_ra", i), m_if.ra_data, vecs[i].exp_ra);
            check($sformatf("vec%0d_rb", i), m_if.rb_data, vecs[i].exp_rb);
            next_cycle();
        end
        m_if.wr_en = 1'b0;

        // Fill with 0xFF, then clear_req together with a write: clear wins
        for (int i = 0; i < 256; i++) begin
            m_if.wr_en = 1'b1; m_if.wr_addr = 8'(i); m_if.wr_data = 8'hFF;
            next_cycle();
        end
        m_if.clear_req = 1'b1;
        m_if.wr_addr = 8'h05; m_if.wr_data = 8'h77;
        m_if.ra_addr = 8'h05; m_if.rb_addr = 8'hC8;
        @(negedge clk);
        check("clr_req_no_bypass", m_if.ra_data, 8'hFF);
        check("clr_req_fill_c8", m_if.rb_data, 8'hFF);
        next_cycle();
        check("clr_req_busy_rise", m_if.busy, 1);
        n = 0;
        bad = 0;
        while (m_if.busy && n < 600) begin
            m_if.clear_req = (n < 10);
            m_if.wr_en = 1'b1; m_if.wr_addr = 8'h06; m_if.wr_data = 8'h99;
            m_if.ra_addr = 8'h06;
            @(negedge clk);
            if (m_if.ra_data !== 8'h00) bad++;
            next_cycle();
            n++;
        end
        m_if.clear_req = 1'b0;
        m_if.wr_en = 1'b0;
        check("clr_req_cycles", n, 256);
        check("clr_req_busy_reads_zero", bad, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            m_if.ra_addr = 8'(i);
            m_if.rb_addr = 8'(255 - i);
            #1;
            if (m_if.ra_data !== 8'h00 || m_if.rb_data !== 8'h00) bad++;
        end
        check("clr_all_entries_zero", bad, 0);
        m_if.ra_addr = 8'h05; m_if.rb_addr = 8'h06;
        @(negedge clk);
        check("clr_dropped_write_05", m_if.ra_data, 8'h00);
        check("clr_dropped_write_06", m_if.rb_data, 8'h00);
        next_cycle();

        // Reset at clr_ptr=100 restarts the full clear
        m_if.clear_req = 1'b1;
        next_cycle();
        m_if.clear_req = 1'b0;
        repeat (100) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("midclr_rst_busy", m_if.busy, 1);
        next_cycle();
        rst = 1'b0;
        count_main_busy(n, bad);
        check("midclr_restart_cycles", n, 256);
        check("midclr_busy_reads_zero", bad, 0);

        // No-bypass instance: old value in the write cycle, new value next cycle
        check("nb_idle", nb_if.busy, 0);
        nb_if.wr_en = 1'b1; nb_if.wr_addr = 8'h20; nb_if.wr_data = 8'h11;
        next_cycle();
        nb_if.wr_data = 8'hC3; nb_if.ra_addr = 8'h20; nb_if.rb_addr = 8'h20;
        @(negedge clk);
        check("nb_same_cycle_ra", nb_if.ra_data, 8'h11);
        check("nb_same_cycle_rb", nb_if.rb_data, 8'h11);
        next_cycle();
        nb_if.wr_en = 1'b0;
        @(negedge clk);
        check("nb_next_cycle_ra", nb_if.ra_data, 8'hC3);
        next_cycle();

        // Zero-register instance with DEPTH=200
        check("z_idle", z_if.busy, 0);
        z_if.wr_en = 1'b1; z_if.wr_addr = 8'd0; z_if.wr_data = 8'hFF; z_if.ra_addr = 8'd0;
        @(negedge clk);
        check("z_addr0_bypass", z_if.ra_data, 8'h00);
        next_cycle();
        z_if.wr_en = 1'b0;
        @(negedge clk);
        check("z_addr0_read", z_if.ra_data, 8'h00);
        next_cycle();
        z_if.wr_en = 1'b1; z_if.wr_addr = 8'd250; z_if.wr_data = 8'h3C; z_if.ra_addr = 8'd250;
        @(negedge clk);
        check("z_oor_bypass", z_if.ra_data, 8'h00);
        next_cycle();
        z_if.wr_en = 1'b0;
        @(negedge clk);
        check("z_oor_read", z_if.ra_data, 8'h00);
        next_cycle();
        z_if.wr_en = 1'b1; z_if.wr_addr = 8'd199; z_if.wr_data = 8'h3C; z_if.ra_addr = 8'd199;
        @(negedge clk);
        check("z_last_bypass", z_if.ra_data, 8'h3C);
        next_cycle();
        z_if.wr_en = 1'b0; z_if.rb_addr = 8'd199; z_if.ra_addr = 8'd198;
        @(negedge clk);
        check("z_last_read", z_if.rb_data, 8'h3C);
        check("z_neighbour_zero", z_if.ra_data, 8'h00);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
